// File: rtl/key_debounce.sv
// key_debounce: two-flop synchroniser and per-key debounce FSM with press/release pulses; optional sticky press flags under KEY_DEBOUNCE_LATCH_EN
module key_debounce #(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_out,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  input  logic [NUM_KEYS-1:0] latch_clr,
  output logic [NUM_KEYS-1:0] press_latched
);
  typedef enum logic {STABLE, COUNTING} state_t;
  logic [NUM_KEYS-1:0] meta, sync;
  // two-stage synchroniser, resets to released (all 1s)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '1;
      sync <= '1;
    end else begin
      meta <= key_raw;
      sync <= meta;
    end
  end
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    state_t state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic out_q, out_nxt, press_q, press_nxt, rel_q, rel_nxt;
    // a new level must differ from key_out for DEBOUNCE_CYCLES consecutive cycles; any bounce back restarts
    always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      out_nxt   = out_q;
      press_nxt = 1'b0;
      rel_nxt   = 1'b0;
      if (state == STABLE) begin
        if (sync[i] != out_q) begin
          state_nxt = COUNTING;
          cnt_nxt   = CNT_W'(1);
        end
      end else if (sync[i] == out_q) begin
        state_nxt = STABLE;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        state_nxt = STABLE;
        out_nxt   = sync[i];
        press_nxt = ~sync[i];
        rel_nxt   = sync[i];
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
    // state, counter, level and pulse registers
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state   <= STABLE;
        cnt     <= '0;
        out_q   <= 1'b1;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        state   <= state_nxt;
        cnt     <= cnt_nxt;
        out_q   <= out_nxt;
        press_q <= press_nxt;
        rel_q   <= rel_nxt;
      end
    end
    assign key_out[i]       = out_q;
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = rel_q;
  end
`ifdef KEY_DEBOUNCE_LATCH_EN
  // sticky press flags: set by a press pulse, cleared by latch_clr, set wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) press_latched <= '0;
    else press_latched <= (press_latched & ~latch_clr) | press_pulse;
  end
`else
  logic unused_latch_clr;
  assign unused_latch_clr = ^latch_clr;
  assign press_latched    = '0;
`endif
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed and randomized checks of key_debounce against a sliding-window model
module tb_key_debounce;
  localparam int D = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] key_raw = 2'b00;
  logic [1:0] latch_clr = 2'b00;
  logic [1:0] key_out, press_pulse, release_pulse, press_latched;
  int vectors = 0;
  int miscompares = 0;
  key_debounce #(.NUM_KEYS(2), .DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .key_raw(key_raw), .key_out(key_out),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .latch_clr(latch_clr), .press_latched(press_latched)
  );
  always #5 clk = ~clk;
  // model: the level the FSM sees is key_raw delayed two edges; a level flips once
  // the last D values it has seen all differ from the current level
  logic [1:0] m_meta, m_sync, m_out, m_press, m_rel, m_lat, flip;
  logic [D-1:0] hist [2];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_meta = '1; m_sync = '1; m_out = '1;
      m_press = '0; m_rel = '0; m_lat = '0;
      for (int k = 0; k < 2; k++) hist[k] = '1;
    end else begin
`ifdef KEY_DEBOUNCE_LATCH_EN
      m_lat = (m_lat & ~latch_clr) | m_press;
`endif
      for (int k = 0; k < 2; k++) begin
        hist[k] = {hist[k][D-2:0], m_sync[k]};
        flip[k] = (hist[k] == {D{~m_out[k]}});
      end
      m_press = flip & m_out;
      m_rel   = flip & ~m_out;
      m_out   = m_out ^ flip;
      m_sync  = m_meta;
      m_meta  = key_raw;
    end
  end
  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask
  // per-cycle comparison against the model
  always @(negedge clk) begin
    check("model key_out", key_out, m_out);
    check("model press_pulse", press_pulse, m_press);
    check("model release_pulse", release_pulse, m_rel);
    check("model press_latched", press_latched, m_lat);
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    tick(3);
    check("reset key_out", key_out, 2'b11);
    check("reset press", press_pulse, 2'b00);
    check("reset release", release_pulse, 2'b00);
    reset = 1'b0;
    tick(9);
    check("held press before edge10", key_out, 2'b11);
    check("held press no early pulse", press_pulse, 2'b00);
    tick(1);
    check("held press key_out", key_out, 2'b00);
    check("held press pulse", press_pulse, 2'b11);
    tick(1);
    check("held press pulse one cycle", press_pulse, 2'b00);
    key_raw = 2'b11;
    tick(12);
    check("release all", key_out, 2'b11);
    key_raw = 2'b10;
    tick(9);
    check("key0 before edge10", key_out, 2'b11);
    tick(1);
    check("key0 key_out", key_out, 2'b10);
    check("key0 press", press_pulse, 2'b01);
    check("key0 no release", release_pulse, 2'b00);
    tick(1);
    check("key0 pulse width", press_pulse, 2'b00);
    check("key0 level held", key_out, 2'b10);
    key_raw = 2'b11;
    tick(12);
    key_raw = 2'b10;
    tick(5);
    key_raw = 2'b11;
    tick(1);
    key_raw = 2'b10;
    tick(9);
    check("glitch restart no accept", key_out, 2'b11);
    check("glitch no pulse", press_pulse, 2'b00);
    tick(1);
    check("glitch accept", key_out, 2'b10);
    check("glitch single press", press_pulse, 2'b01);
    key_raw = 2'b00;
    tick(12);
    check("both pressed", key_out, 2'b00);
    key_raw = 2'b11;
    tick(10);
    check("both release pulse", release_pulse, 2'b11);
    check("both released", key_out, 2'b11);
    tick(3);
    key_raw = 2'b10;
    tick(7);
    reset = 1'b1;
    #1;
    check("mid-count reset key_out", key_out, 2'b11);
    check("mid-count reset pulse", press_pulse, 2'b00);
    tick(3);
    reset = 1'b0;
    tick(9);
    check("re-debounce not yet", key_out, 2'b11);
    tick(1);
    check("re-debounce key_out", key_out, 2'b10);
    check("re-debounce press", press_pulse, 2'b01);
    tick(1);
`ifdef KEY_DEBOUNCE_LATCH_EN
    check("latch set", press_latched, 2'b01);
    latch_clr = 2'b01;
    tick(1);
    latch_clr = 2'b00;
    check("latch cleared", press_latched, 2'b00);
`else
    check("latch tied off", press_latched, 2'b00);
`endif
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 2; k++)
        if ($urandom_range(c < 2000 ? 7 : 15) == 0) key_raw[k] = ~key_raw[k];
      latch_clr = ($urandom_range(15) == 0) ? 2'($urandom_range(3)) : 2'b00;
      reset = ($urandom_range(599) == 0);
      tick(1);
    end
    reset = 1'b0;
    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
